sipo_deframer: RTL and testbench



---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_sync_matcher.sv | 36 +++
 rtl/sipo_deframer.sv | 176 +++++++++++++++++
 tb/tb_sipo_deframer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-to-parallel deframer.
// The optional parity stage is built in by defining SIPO_DEFRAMER_PARITY_EN.
package sipo_pkg;

    localparam int         WIDTH_DEF    = 8;
    localparam int         SYNC_W_DEF   = 4;
    localparam logic [3:0] SYNC_PAT_DEF = 4'b1011;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_e;

    // The counter must be able to hold WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_sync_matcher.sv
// Sliding sync-pattern window. match is asserted on the sampling edge whose
// updated window equals SYNC_PAT, so overlapping candidates are found.
module sipo_sync_matcher
    import sipo_pkg::*;
#(
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic serial_in,
    input  logic clear,
    output logic match
);

    logic [SYNC_W-1:0] win_q;
    logic [SYNC_W-1:0] win_d;

    assign win_d = {win_q[SYNC_W-2:0], serial_in};
    assign match = bit_en & (win_d == SYNC_PAT);

    // Window register: clear wins over shifting so a lock starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= {SYNC_W{1'b0}};
        end else if (clear) begin
            win_q <= {SYNC_W{1'b0}};
        end else if (bit_en) begin
            win_q <= win_d;
        end else begin
            win_q <= win_q;
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Sync hunt, MSB-first word collection and one-entry output holding register.
// Define SIPO_DEFRAMER_PARITY_EN to add a trailing even-parity bit per frame.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int                WIDTH    = WIDTH_DEF,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             par_err
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               perr_q, perr_d;
    logic               busy_q, busy_d;

    logic               hunt_en_s;
    logic               match_s;
    logic               commit_s;
    logic               ovf_set_s;
    logic [WIDTH-1:0]   word_s;
    logic               word_perr_s;

    assign hunt_en_s = bit_en & (state_q == HUNT);

    sipo_sync_matcher #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_matcher (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (hunt_en_s),
        .serial_in (serial_in),
        .clear     (match_s),
        .match     (match_s)
    );

    // Frame FSM, data shifting and holding-register commit/handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        perr_d      = perr_q;
        commit_s    = 1'b0;
        ovf_set_s   = 1'b0;
        word_s      = shreg_q;
        word_perr_s = 1'b0;

        case (state_q)
            HUNT: begin
                if (match_s) begin
                    state_d = COLLECT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = HUNT;
                end
            end
            COLLECT: begin
                if (bit_en) begin
                    shreg_d = {shreg_q[WIDTH-2:0], serial_in};
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_IDX) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
                        state_d  = PARITY;
`else
                        state_d  = HUNT;
                        commit_s = 1'b1;
                        word_s   = shreg_d;
`endif
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            PARITY: begin
`ifdef SIPO_DEFRAMER_PARITY_EN
                if (bit_en) begin
                    state_d     = HUNT;
                    commit_s    = 1'b1;
                    word_s      = shreg_q;
                    word_perr_s = ^{shreg_q, serial_in};
                end else begin
                    state_d = PARITY;
                end
`else
                state_d = HUNT;
`endif
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        // A drain on the commit edge frees the slot for the new word.
        if (commit_s) begin
            if (!valid_q || dout_ready) begin
                dout_d  = word_s;
                valid_d = 1'b1;
                perr_d  = word_perr_s;
            end else begin
                ovf_set_s = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        busy_d = (state_d != HUNT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= {CNT_W{1'b0}};
            shreg_q <= {WIDTH{1'b0}};
            dout_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
`ifdef SIPO_DEFRAMER_PARITY_EN
    assign par_err    = perr_q;
`else
    assign par_err    = perr_q & 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Scoreboard bench for sipo_deframer: a bit-level framing model feeds an
// expected-word queue that a negedge monitor drains against the DUT.
module tb_sipo_deframer;

    localparam int         WIDTH    = 8;
    localparam int         SYNC_W   = 4;
    localparam logic [3:0] SYNC_PAT = 4'b1011;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             serial_in = 1'b0;
    logic             bit_en = 1'b0;
    logic             dout_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             overflow;
    logic             par_err;

    sipo_deframer #(
        .WIDTH    (WIDTH),
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (frame level, not cycle level).
    bit          m_hist[$];
    bit          m_in_frame = 1'b0;
    int          m_n = 0;
    logic [31:0] m_word = 32'd0;
    bit          m_full = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] last_w = 32'd0;
    logic        last_p = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Feed one sampled bit to the framing model; reports a completed frame.
    task automatic model_bit(input bit b, output bit done, output logic [31:0] w, output logic p);
        int v;
        done = 1'b0;
        w    = 32'd0;
        p    = 1'b0;
        if (!m_in_frame) begin
            m_hist.push_back(b);
            if (m_hist.size() > SYNC_W) void'(m_hist.pop_front());
            if (m_hist.size() == SYNC_W) begin
                v = 0;
                foreach (m_hist[i]) v = v * 2 + int'(m_hist[i]);
                if (v == int'(SYNC_PAT)) begin
                    m_in_frame = 1'b1;
                    m_n        = 0;
                    m_word     = 32'd0;
                    m_hist.delete();
                end
            end
        end else if (m_n < WIDTH) begin
            m_word = m_word * 2 + 32'(b);
            m_n++;
`ifndef SIPO_DEFRAMER_PARITY_EN
            if (m_n == WIDTH) begin
                done = 1'b1;
                w    = m_word;
                m_in_frame = 1'b0;
            end
`endif
        end else begin
            done = 1'b1;
            w    = m_word;
            p    = logic'((($countones(m_word) + int'(b)) % 2) != 0);
            m_in_frame = 1'b0;
        end
    endtask

    // Drive one clock of inputs; model effects become visible after the edge.
    task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
        bit          done;
        bit          drop;
        logic [31:0] w;
        logic        p;
        exp_t        e;
        bit_en     = en;
        serial_in  = b;
        dout_ready = rdy;
        ovf_clr    = clr;
        done = 1'b0;
        drop = 1'b0;
        w    = 32'd0;
        p    = 1'b0;
        if (en) model_bit(b, done, w, p);
        if (done) begin
            if (!m_full || rdy) m_full = 1'b1;
            else drop = 1'b1;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        if (done && !drop) begin
            e.w = w;
            e.p = p;
            sb.push_back(e);
        end
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        exp_busy = m_in_frame;
        #1;
    endtask

    task automatic send_val(input logic [31:0] v, input int n, input int gap, input logic rdy);
        logic [31:0] t;
        for (int i = n - 1; i >= 0; i--) begin
            t = v >> i;
            step(1'b1, t[0], rdy, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, logic'($urandom_range(1)), rdy, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int gap, input logic rdy, input logic pbit);
        send_val(32'(SYNC_PAT), SYNC_W, gap, rdy);
        send_val(w, WIDTH, gap, rdy);
`ifdef SIPO_DEFRAMER_PARITY_EN
        send_val({31'd0, pbit}, 1, gap, rdy);
`else
        if (pbit !== 1'b0 && pbit !== 1'b1) $display("note: undefined parity bit ignored");
`endif
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        bit_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_perr", 32'(par_err), 32'd0);
        sb.delete();
        m_hist.delete();
        m_in_frame = 1'b0;
        m_n        = 0;
        m_full     = 1'b0;
        exp_ovf    = 1'b0;
        exp_busy   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares the holding register against the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", 32'(dout_valid), 32'(sb.size() > 0));
            if (dout_valid && sb.size() > 0) begin
                chk("dout", 32'(dout), sb[0].w);
                chk("par_err", 32'(par_err), 32'(sb[0].p));
                if (dout_ready) begin
                    last_w = sb[0].w;
                    last_p = sb[0].p;
                    void'(sb.pop_front());
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
        end
    end

    initial begin
        #2;
        do_reset();

        // Basic frame, continuous bits.
        send_frame(32'hCA, 0, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("t1_word", last_w, 32'h0000_00CA);

        // Same frame with 3-cycle gaps between sampled bits.
        last_w = 32'd0;
        send_frame(32'hCA, 3, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("t2_word", last_w, 32'h0000_00CA);

        // Backpressure: second frame dropped, first held.
        send_frame(32'hCA, 0, 1'b0, 1'b0);
        send_frame(32'h35, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t3_hold", 32'(dout), 32'h0000_00CA);
        chk("t3_valid", 32'(dout_valid), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_drain", 32'(dout_valid), 32'd0);

        // Garbage with an overlapping sync candidate.
        last_w = 32'd0;
        send_val(32'b0101011, 7, 0, 1'b1);
        send_val(32'hFF, WIDTH, 0, 1'b1);
`ifdef SIPO_DEFRAMER_PARITY_EN
        send_val(32'd0, 1, 0, 1'b1);
`endif
        idle(3, 1'b1);
        chk("t4_word", last_w, 32'h0000_00FF);

        // Reset after 5 data bits, then a clean frame.
        send_val(32'(SYNC_PAT), SYNC_W, 0, 1'b1);
        send_val(32'b10110, 5, 0, 1'b1);
        do_reset();
        idle(4, 1'b1);
        last_w = 32'd0;
        send_frame(32'h0F, 0, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("t5_word", last_w, 32'h0000_000F);

`ifdef SIPO_DEFRAMER_PARITY_EN
        send_frame(32'hCA, 0, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("t6_perr0", 32'(last_p), 32'd0);
        send_frame(32'hCA, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("t6_perr1", 32'(last_p), 32'd1);
        chk("t6_word", last_w, 32'h0000_00CA);
`endif

        // Randomized traffic with backpressure and overflow clears.
        for (int i = 0; i < 4000; i++) begin
            step(logic'($urandom_range(9) < 7), logic'($urandom_range(1)),
                 logic'($urandom_range(1)), logic'($urandom_range(19) == 0));
        end
        idle(4, 1'b1);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
